// File: rtl/sn_stream_gen.sv
// rtl/sn_stream_gen.sv - binary-to-stochastic bitstream generator with valid/ready handshake
module sn_stream_gen #(
  parameter int N_CH       = 4,
  parameter int W          = 4,
  parameter int PHASE_STEP = 0
) (
  input  logic              i_clk_sn_gen,
  input  logic              i_rst_sn_gen,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [N_CH*W-1:0] i_x,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_valid,
  output logic [N_CH-1:0]   o_sn_bit,
  output logic              o_last,
  output logic              o_done
);

  localparam int L = 1 << W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [W-1:0]        c_q, c_d;
  logic [N_CH*W-1:0]   x_q, x_d;
  logic [N_CH-1:0]     sn_raw;

  // Bit chosen for one slot: skip past the trailing ones of the slot index, the
  // count selects an operand bit from the MSB down; the all-ones slot emits 0.
  function automatic logic slot_bit(input logic [W-1:0] s, input logic [W-1:0] xj);
    int   t;
    logic run;
    t   = 0;
    run = 1'b1;
    for (int k = 0; k < W; k++) begin
      if (run && s[k]) begin
        t = t + 1;
      end else begin
        run = 1'b0;
      end
    end
    if (t == W) begin
      return 1'b0;
    end
    return xj[W-1-t];
  endfunction

  // State, beat counter and frozen operand registers
  always_ff @(posedge i_clk_sn_gen) begin
    if (i_rst_sn_gen) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      x_q     <= x_d;
    end
  end

  // Next-state and control outputs; stop beats a completing beat in GEN
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    x_d     = x_q;
    o_busy  = 1'b0;
    o_valid = 1'b0;
    o_last  = 1'b0;
    o_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          x_d     = i_x;
          c_d     = '0;
          state_d = ST_GEN;
        end
      end
      ST_GEN: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        o_last  = &c_q;
        if (i_stop) begin
          c_d     = '0;
          state_d = ST_IDLE;
        end else if (i_ready) begin
          if (&c_q) begin
            c_d     = '0;
            state_d = ST_DONE;
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        o_busy  = 1'b1;
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Per-channel slot index with phase offset, then mux of the operand bit
  always_comb begin
    sn_raw = '0;
    for (int j = 0; j < N_CH; j++) begin
      sn_raw[j] = slot_bit(c_q + W'((j * PHASE_STEP) % L), x_q[j*W +: W]);
    end
  end

  // Stream bits are only driven while a beat is being offered
  always_comb begin
    o_sn_bit = o_valid ? sn_raw : '0;
  end

endmodule

// File: tb/tb_sn_stream_gen.sv
// tb/tb_sn_stream_gen.sv - self-checking bench for sn_stream_gen
module tb_sn_stream_gen;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int PS = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic          i_stop;
  logic [N*W-1:0] i_x;
  logic          i_ready;
  logic          o_busy;
  logic          o_valid;
  logic [N-1:0]  o_sn_bit;
  logic          o_last;
  logic          o_done;

  int errors = 0;
  int checks = 0;

  sn_stream_gen #(.N_CH(N), .W(W), .PHASE_STEP(PS)) dut (
    .i_clk_sn_gen (clk),
    .i_rst_sn_gen (rst),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_x          (i_x),
    .i_ready      (i_ready),
    .o_busy       (o_busy),
    .o_valid      (o_valid),
    .o_sn_bit     (o_sn_bit),
    .o_last       (o_last),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: operand bit k is placed on slots whose index ends in exactly
  // (W-1-k) ones; the slot whose index is all ones carries a zero.
  function automatic logic model_bit(input logic [3:0] xj, input int beat, input int ch);
    int s;
    int t;
    s = (beat + ch * PS) % 16;
    t = 0;
    while (s % 2 == 1) begin
      s = s / 2;
      t++;
    end
    if (t == 4) return 1'b0;
    return xj[3-t];
  endfunction

  function automatic logic [3:0] model_vec(input logic [15:0] x, input int beat);
    logic [3:0] v;
    for (int ch = 0; ch < N; ch++) v[ch] = model_bit(x[ch*4 +: 4], beat, ch);
    return v;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  o_busy,   1'b0);
    check({tag, "_valid"}, o_valid,  1'b0);
    check({tag, "_sn"},    o_sn_bit, 4'h0);
    check({tag, "_last"},  o_last,   1'b0);
    check({tag, "_done"},  o_done,   1'b0);
  endtask

  // One full stream: mode 0 ready=1, mode 1 toggling (starts low), mode 2 random
  task automatic run_stream(input logic [15:0] x, input int mode, input bit hold_start,
                            input bit stop_with_start, output logic [3:0][15:0] seq);
    int c;
    int cyc;
    bit rdy;
    int ones [4];
    seq = '0;
    for (int ch = 0; ch < N; ch++) ones[ch] = 0;
    i_x     = x;
    i_start = 1'b1;
    i_stop  = stop_with_start;
    step();
    if (!hold_start) i_start = 1'b0;
    i_stop = 1'b0;
    c   = 0;
    cyc = 0;
    while (c < 16 && cyc < 200) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
      i_ready = rdy;
      i_x     = $urandom();
      check("gen_valid", o_valid, 1'b1);
      check("gen_busy",  o_busy,  1'b1);
      check("gen_done",  o_done,  1'b0);
      check("gen_last",  o_last,  (c == 15));
      check("gen_sn",    o_sn_bit, model_vec(x, c));
      if (rdy) begin
        for (int ch = 0; ch < N; ch++) begin
          seq[ch][15-c] = o_sn_bit[ch];
          ones[ch] += int'(o_sn_bit[ch]);
        end
      end
      step();
      cyc++;
      if (rdy) c++;
    end
    check("beats_completed", c, 16);
    if (mode == 0) check("gen_cycles_ready", cyc, 16);
    if (mode == 1) check("gen_cycles_toggle", cyc, 32);
    i_ready = 1'($urandom_range(0, 1));
    check("done_pulse", o_done,   1'b1);
    check("done_busy",  o_busy,   1'b1);
    check("done_valid", o_valid,  1'b0);
    check("done_sn",    o_sn_bit, 4'h0);
    i_start = 1'b0;
    step();
    check("after_done_pulse", o_done, 1'b0);
    check("after_done_busy",  o_busy, 1'b0);
    check("after_done_valid", o_valid, 1'b0);
    for (int ch = 0; ch < N; ch++) check("ones_count", ones[ch], x[ch*4 +: 4]);
  endtask

  // Start a stream and complete n beats with ready held high
  task automatic start_and_advance(input logic [15:0] x, input int n);
    i_x     = x;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int b = 0; b < n; b++) begin
      i_ready = 1'b1;
      check("adv_sn", o_sn_bit, model_vec(x, b));
      step();
    end
  endtask

  logic [3:0][15:0] seq;

  initial begin
    rst     = 1'b1;
    i_start = 1'b0;
    i_stop  = 1'b0;
    i_x     = '0;
    i_ready = 1'b0;
    step();
    step();
    check_idle("reset");
    rst = 1'b0;
    step();
    check_idle("idle");

    // Operand 0xA on every channel: ch0 aligned, ch1 one slot ahead
    run_stream(16'hAAAA, 0, 1'b0, 1'b0, seq);
    check("t1_ch0_seq", seq[0], 16'hBABA);
    check("t5_ch1_seq", seq[1], 16'h7575);

    // Zero operand and full operand
    run_stream(16'h00F0, 0, 1'b0, 1'b0, seq);
    check("t2_ch0_zero", seq[0], 16'h0000);
    check("t2_ch1_full", seq[1], 16'hFFFD);

    // Backpressure with a toggling ready
    run_stream(16'hAAAA, 1, 1'b0, 1'b0, seq);
    check("t3_ch0_seq", seq[0], 16'hBABA);

    // Abort together with a ready beat at c=5
    start_and_advance(16'h000A, 5);
    i_stop  = 1'b1;
    i_ready = 1'b1;
    check("t4_last_before_stop", o_sn_bit[0], model_bit(4'hA, 5, 0));
    step();
    i_stop = 1'b0;
    check_idle("t4_abort");
    step();
    check_idle("t4_no_done");

    // Restart after abort, with stop and start together in IDLE
    run_stream(16'h000A, 0, 1'b0, 1'b1, seq);
    check("t4_restart_seq", seq[0], 16'hBABA);

    // Synchronous reset in the middle of a stream
    start_and_advance(16'h3C5A, 7);
    rst = 1'b1;
    step();
    check_idle("t6_reset");
    rst = 1'b0;
    step();
    check_idle("t6_after_reset");

    // Start held high through GEN and DONE must not retrigger
    run_stream(16'h9E17, 0, 1'b1, 1'b0, seq);
    step();
    check_idle("t6_no_retrigger");

    // Random operands with random backpressure
    for (int r = 0; r < 6; r++) begin
      run_stream(16'($urandom()), 2, 1'b0, 1'b0, seq);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
